// File: rtl/lowest_free_slot_allocator.sv
// Lowest-free slot allocator: used-slot bitmap, rightmost-zero grant, multi-hot release.
// Optional RELEASE_BYPASS_EN lets a slot released this cycle be granted in the same cycle.
module lowest_free_slot_allocator #(
  parameter int SLOT_COUNT = 8
) (
  input  logic                             clock,
  input  logic                             clear,
  input  logic                             alloc_valid,
  output logic                             alloc_ready,
  output logic [SLOT_COUNT-1:0]            alloc_slot,
  input  logic                             release_valid,
  input  logic [SLOT_COUNT-1:0]            release_mask,
  output logic [SLOT_COUNT-1:0]            used_map,
  output logic [$clog2(SLOT_COUNT+1)-1:0]  free_count,
  output logic                             full,
  output logic                             empty,
  output logic                             release_error
);

  localparam int COUNT_WIDTH = $clog2(SLOT_COUNT + 1);

  function automatic logic [COUNT_WIDTH-1:0] popcount(input logic [SLOT_COUNT-1:0] v);
    logic [COUNT_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      n = n + COUNT_WIDTH'(v[i]);
    end
    return n;
  endfunction

  logic [SLOT_COUNT-1:0]  rel_eff;
  logic [SLOT_COUNT-1:0]  cand;
  logic [SLOT_COUNT-1:0]  cand_inc;
  logic [SLOT_COUNT-1:0]  rel_hit;
  logic [SLOT_COUNT-1:0]  next_map;
  logic [COUNT_WIDTH-1:0] next_free;
  logic                   grant;

  always_comb begin
    rel_eff = release_valid ? release_mask : '0;
`ifdef RELEASE_BYPASS_EN
    cand = used_map & ~rel_eff;
`else
    cand = used_map;
`endif
    // Rightmost zero of cand; carry out dropped so an all-ones map grants nothing.
    cand_inc    = cand + SLOT_COUNT'(1);
    alloc_slot  = ~cand & cand_inc;
    alloc_ready = |alloc_slot;
    grant       = alloc_valid & alloc_ready;
    rel_hit     = rel_eff & used_map;
    next_map    = (used_map & ~rel_eff) | (grant ? alloc_slot : '0);
    next_free   = free_count + popcount(rel_hit) - COUNT_WIDTH'(grant);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      used_map      <= '0;
      free_count    <= COUNT_WIDTH'(SLOT_COUNT);
      full          <= 1'b0;
      empty         <= 1'b1;
      release_error <= 1'b0;
    end else begin
      used_map      <= next_map;
      free_count    <= next_free;
      full          <= &next_map;
      empty         <= ~|next_map;
      release_error <= release_error | (|(rel_eff & ~used_map));
    end
  end

endmodule

// File: tb/tb_lowest_free_slot_allocator.sv
// Directed plus randomized bench for lowest_free_slot_allocator against a slot-array reference model.
module tb_lowest_free_slot_allocator;
  localparam int N = 8;

  logic         clock = 1'b0;
  logic         clear = 1'b1;
  logic         alloc_valid = 1'b0;
  logic         alloc_ready;
  logic [N-1:0] alloc_slot;
  logic         release_valid = 1'b0;
  logic [N-1:0] release_mask = '0;
  logic [N-1:0] used_map;
  logic [3:0]   free_count;
  logic         full;
  logic         empty;
  logic         release_error;

  int checks = 0;
  int errors = 0;

  bit m_used [N];
  bit m_err;

  lowest_free_slot_allocator #(.SLOT_COUNT(N)) dut (
    .clock(clock), .clear(clear), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_slot(alloc_slot), .release_valid(release_valid), .release_mask(release_mask),
    .used_map(used_map), .free_count(free_count), .full(full), .empty(empty),
    .release_error(release_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model_map();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_used[i];
    return v;
  endfunction

  function automatic int model_free();
    int f = 0;
    for (int i = 0; i < N; i++) if (!m_used[i]) f++;
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_used[i] = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".used_map"}, 32'(used_map), 32'(model_map()));
    check({tag, ".free_count"}, 32'(free_count), 32'(model_free()));
    check({tag, ".full"}, 32'(full), 32'(model_free() == 0));
    check({tag, ".empty"}, 32'(empty), 32'(model_free() == N));
    check({tag, ".release_error"}, 32'(release_error), 32'(m_err));
  endtask

  // Entered and left at posedge+1: drive, check grant, clock, check registered state.
  task automatic cycle(input string tag, input logic av, input logic rv, input logic [N-1:0] rm);
    int g;
    bit freed_by_rel;
    alloc_valid   = av;
    release_valid = rv;
    release_mask  = rm;
    #2;
    g = -1;
    for (int i = 0; i < N; i++) begin
      freed_by_rel = 1'b0;
`ifdef RELEASE_BYPASS_EN
      freed_by_rel = rv && rm[i];
`endif
      if (g < 0 && (!m_used[i] || freed_by_rel)) g = i;
    end
    check({tag, ".alloc_ready"}, 32'(alloc_ready), 32'(g >= 0));
    check({tag, ".alloc_slot"}, 32'(alloc_slot), (g >= 0) ? (32'd1 << g) : 32'd0);
    if (rv) begin
      for (int i = 0; i < N; i++) begin
        if (rm[i]) begin
          if (!m_used[i]) m_err = 1'b1;
          m_used[i] = 1'b0;
        end
      end
    end
    if (av && g >= 0) m_used[g] = 1'b1;
    @(posedge clock);
    #1;
    check_state(tag);
  endtask

  task automatic pulse_clear(input string tag);
    alloc_valid   = 1'b0;
    release_valid = 1'b0;
    release_mask  = '0;
    clear = 1'b1;
    #1;
    model_reset();
    check_state(tag);
    check({tag, ".alloc_slot"}, 32'(alloc_slot), 32'h01);
    check({tag, ".alloc_ready"}, 32'(alloc_ready), 32'h1);
    #1;
    clear = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [N-1:0] rm;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_state("reset");
    check("reset.alloc_slot", 32'(alloc_slot), 32'h01);
    clear = 1'b0;
    @(posedge clock);
    #1;

    // Hold request through fill and one cycle past full.
    for (int k = 0; k < 9; k++) cycle("fill", 1'b1, 1'b0, '0);
    check("fill.used_map_const", 32'(used_map), 32'hFF);
    check("fill.full_const", 32'(full), 32'h1);

    cycle("rel24", 1'b0, 1'b1, 8'h24);
    check("rel24.used_const", 32'(used_map), 32'hDB);
    cycle("grant04", 1'b1, 1'b0, '0);
    cycle("grant20", 1'b1, 1'b0, '0);

    pulse_clear("clr1");
    for (int k = 0; k < 7; k++) cycle("to7f", 1'b1, 1'b0, '0);
    cycle("msb", 1'b1, 1'b0, '0);
    check("msb.full_const", 32'(full), 32'h1);

    pulse_clear("clr2");
    for (int k = 0; k < 4; k++) cycle("to0f", 1'b1, 1'b0, '0);
    cycle("badrel", 1'b0, 1'b1, 8'h30);
    check("badrel.err_const", 32'(release_error), 32'h1);
    for (int k = 0; k < 3; k++) cycle("sticky", 1'b0, 1'b0, '0);

    pulse_clear("clr3");
    for (int k = 0; k < 8; k++) cycle("tofull", 1'b1, 1'b0, '0);
    cycle("fullrel", 1'b1, 1'b1, 8'h01);
    cycle("afterrel", 1'b1, 1'b0, '0);

    pulse_clear("clr4");
    for (int k = 0; k < 6; k++) cycle("to3f", 1'b1, 1'b0, '0);
    cycle("to3c", 1'b0, 1'b1, 8'h03);
    check("to3c.used_const", 32'(used_map), 32'h3C);
    pulse_clear("midclr");

    for (int k = 0; k < 400; k++) begin
      if (k % 100 == 99) pulse_clear("rclr");
      rm = N'($urandom);
      if ($urandom_range(0, 9) != 0) rm = rm & model_map();
      cycle("rand", 1'(($urandom_range(0, 3) != 0)), 1'(($urandom_range(0, 9) < 4)), rm);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lowest_free_slot_allocator.md
# lowest_free_slot_allocator

Tracks ownership of SLOT_COUNT identical shared resources (buffer entries, tags, DSP lanes) in a used-slot bitmap. It grants the lowest-numbered free slot to a single requester through a valid/ready handshake and accepts releases as a one-hot-or-multi-hot mask. Rightmost-bit arithmetic on the bitmap picks the lowest free slot without a priority encoder. Sits between a request source and a pool of resources, as the scheduler that shares that pool.

## Interface
- SLOT_COUNT, 8, number of managed slots (>= 1).
- COUNT_WIDTH, derived, clog2(SLOT_COUNT+1); not overridable.

- clock  input  1  sole clock; all state changes on rising edge.
- clear  input  1  asynchronous, active-high reset.
- alloc_valid  input  1  requester wants one slot.
- alloc_ready  output  1  a slot is available this cycle.
- alloc_slot  output  SLOT_COUNT  one-hot slot granted on alloc_valid & alloc_ready; all-zero when alloc_ready is low.
- release_valid  input  1  release_mask is meaningful this cycle.
- release_mask  input  SLOT_COUNT  slots to free; any number of bits.
- used_map  output  SLOT_COUNT  registered bitmap, bit i = slot i allocated.
- free_count  output  COUNT_WIDTH  registered count of zero bits in used_map.
- full  output  1  registered; used_map all ones.
- empty  output  1  registered; used_map all zeros.
- release_error  output  1  sticky; set by releasing an unallocated slot.

## Operation
- Candidate map C: used_map (see Configuration for bypass).
- alloc_slot = ~C & (C + 1), at SLOT_COUNT width. This isolates the rightmost zero. The carry out is discarded, so all-ones C gives zero.
- alloc_ready = |alloc_slot.
- Grant fires when alloc_valid & alloc_ready. Next used_map gets alloc_slot ORed in (C | (C + 1)).
- Release fires when release_valid. Next used_map gets release_mask bits cleared.
- Next used_map = (used_map & ~(release_valid ? release_mask : 0)) | (grant ? alloc_slot : 0).
- Release bits not set in used_map are ignored for state and set release_error. It stays set until clear.
- free_count is updated as free_count + popcount(valid released bits) - grant. Releases of unallocated bits do not count. It must always equal SLOT_COUNT minus popcount(used_map).
- full and empty are recomputed from next used_map and registered with it.
- No internal FSM beyond the bitmap, counter and sticky flag. The requester may hold alloc_valid indefinitely. Each cycle with alloc_ready high grants one slot.

## Timing
- Reset values:
  - used_map = 0
  - free_count = SLOT_COUNT
  - full = 0 (1 if SLOT_COUNT = 0 is disallowed, so always 0)
  - empty = 1
  - release_error = 0
  - alloc_ready = 1 and alloc_slot = 1 (bit 0), combinationally after reset.
- Grant latency 0: alloc_slot is valid in the same cycle as the handshake, and the slot shows in used_map on the next edge.
- Release latency 1: the slot is visible as free on the next edge (without bypass).
- Simultaneous grant and release in one cycle: both are applied. The grant is chosen from C, never from a slot being released (without bypass).
- At full: alloc_ready = 0 and alloc_slot = 0, and alloc_valid is ignored. A release that cycle raises alloc_ready on the following cycle.
- Wrap: only the top slot free means C + 1 carries through all lower ones; the grant is the MSB. No index wrap exists.
- clear asserted mid-operation: all state returns to reset values immediately. Outstanding grants are forgotten.

## Configuration
- RELEASE_BYPASS_EN
  - Defined: C = used_map & ~(release_valid ? release_mask : 0). A slot released this cycle can be granted in the same cycle. At full with a concurrent release, alloc_ready = 1 in that cycle. A bypassed slot both released and granted ends set in used_map, and free_count is unchanged for it.
  - Undefined: C = used_map, and alloc_ready depends only on registered state. This is the shorter combinational path.

## Test plan
- Reset then hold alloc_valid for 9 cycles (SLOT_COUNT=8) -> alloc_slot 0x01, 0x02, 0x04 … 0x80, then 0x00 with alloc_ready=0. After that, used_map=0xFF, full=1, free_count=0.
- used_map=0xFF, release_mask=0x24 -> next used_map=0xDB, free_count=2. The next grant is 0x04, then 0x20.
- used_map=0x7F, alloc_valid -> alloc_slot=0x80 (carry through low bits), then full=1.
- used_map=0x0F, release_mask=0x30 (unallocated) -> used_map stays 0x0F, release_error=1 and stays 1 until clear.
- used_map=0xFF, simultaneous release_mask=0x01 and alloc_valid -> without RELEASE_BYPASS_EN: no grant, used_map=0xFE. With it: alloc_slot=0x01, used_map stays 0xFF, free_count=0.
- clear pulsed mid-sequence with used_map=0x3C -> used_map=0, free_count=8, empty=1, alloc_slot=0x01 immediately.
